// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types, control-vector encodings and hazard helper for the stall/flush sequencer.
package pipe_stall_ctrl_pkg;

    typedef enum logic [0:0] {
        StRun   = 1'b0,
        StMwait = 1'b1
    } state_e;

    localparam logic [4:0] RegZero = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idexe_en;
        logic idexe_flush;
        logic exemem_en;
        logic memwb_flush;
    } ctrl_t;

    localparam ctrl_t CtrlOff = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                  idexe_en: 1'b0, idexe_flush: 1'b0, exemem_en: 1'b0,
                                  memwb_flush: 1'b0};

    localparam ctrl_t CtrlRun = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                  idexe_en: 1'b1, idexe_flush: 1'b0, exemem_en: 1'b1,
                                  memwb_flush: 1'b0};

    // Whole pipe frozen; MEM/WB gets a bubble so the waiting op is not written back twice.
    localparam ctrl_t CtrlFreeze = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                     idexe_en: 1'b0, idexe_flush: 1'b0, exemem_en: 1'b0,
                                     memwb_flush: 1'b1};

    localparam ctrl_t CtrlSquash = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                     idexe_en: 1'b1, idexe_flush: 1'b1, exemem_en: 1'b1,
                                     memwb_flush: 1'b0};

    localparam ctrl_t CtrlBubble = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                     idexe_en: 1'b1, idexe_flush: 1'b1, exemem_en: 1'b1,
                                     memwb_flush: 1'b0};

    function automatic logic load_use(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic uses_rs, input logic uses_rt,
                                      input logic [4:0] wraddr, input logic wr_en,
                                      input logic is_load);
        logic match_rs;
        logic match_rt;
        match_rs = uses_rs & (rs == wraddr);
        match_rt = uses_rt & (rt == wraddr);
        return is_load & wr_en & (wraddr != RegZero) & (match_rs | match_rt);
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear, asynchronous active-high reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en && (q_q != {W{1'b1}})) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch squash,
// data-memory wait freeze with timeout flag, and a saturating stall-cycle counter.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rs,
    input  logic             ID_uses_rt,
    input  logic [4:0]       EXE_wraddr,
    input  logic             EXE_wr_en,
    input  logic             EXE_is_load,
    input  logic             EXE_br_taken,
    input  logic             MEM_mem_op,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idexe_en,
    output logic             idexe_flush,
    output logic             exemem_en,
    output logic             memwb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic             mem_hold;
    logic             hazard;
    ctrl_t            ctrl;

    // Mealy request: a fresh MEM op asks immediately, an outstanding one keeps asking.
    always_comb begin
        dmem_req = 1'b0;
        if (!rst) begin
            dmem_req = (state_q == StMwait) ? 1'b1 : MEM_mem_op;
        end
    end

    assign mem_hold = dmem_req & ~dmem_ack;

    assign hazard = load_use(ID_rs, ID_rt, ID_uses_rs, ID_uses_rt,
                             EXE_wraddr, EXE_wr_en, EXE_is_load);

    always_comb begin
        ctrl = CtrlRun;
        if (rst) begin
            ctrl = CtrlOff;
        end else if (mem_hold) begin
            ctrl = CtrlFreeze;
        end else if (EXE_br_taken) begin
            ctrl = CtrlSquash;
        end else if (hazard) begin
            ctrl = CtrlBubble;
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign ifid_en     = ctrl.ifid_en;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idexe_en    = ctrl.idexe_en;
    assign idexe_flush = ctrl.idexe_flush;
    assign exemem_en   = ctrl.exemem_en;
    assign memwb_flush = ctrl.memwb_flush;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        unique case (state_q)
            StRun: begin
                if (mem_hold) begin
                    state_d    = StMwait;
                    wait_cnt_d = WaitW'(1);
                end
            end
            StMwait: begin
                if (dmem_ack) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else begin
                    // Timeout only flags the error; the access keeps waiting for its ack.
                    if (wait_cnt_q == WaitW'(MAX_WAIT - 1)) begin
                        mem_err_d = 1'b1;
                    end
                    if (wait_cnt_q < WaitW'(MAX_WAIT)) begin
                        wait_cnt_d = wait_cnt_q + WaitW'(1);
                    end
                end
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (~rst & ~pc_en),
        .clr (1'b0),
        .q   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed and randomized bench for pipe_stall_ctrl against a behavioural reference model.
module tb_pipe_stall_ctrl;

    localparam int unsigned MaxWait = 16;
    localparam int unsigned CntW    = 16;
    localparam int          CntMax  = 65535;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      ID_rs, ID_rt, EXE_wraddr;
    logic            ID_uses_rs, ID_uses_rt, EXE_wr_en, EXE_is_load, EXE_br_taken;
    logic            MEM_mem_op, dmem_ack;
    logic            dmem_req, pc_en, ifid_en, ifid_flush, idexe_en, idexe_flush;
    logic            exemem_en, memwb_flush, mem_err;
    logic [CntW-1:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending access flag, consecutive frozen cycles, sticky error, stalls.
    bit m_wait;
    int m_frozen;
    bit m_err;
    int m_stalls;
    int base;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .MAX_WAIT (MaxWait),
        .CNT_W    (CntW)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .ID_rs        (ID_rs),
        .ID_rt        (ID_rt),
        .ID_uses_rs   (ID_uses_rs),
        .ID_uses_rt   (ID_uses_rt),
        .EXE_wraddr   (EXE_wraddr),
        .EXE_wr_en    (EXE_wr_en),
        .EXE_is_load  (EXE_is_load),
        .EXE_br_taken (EXE_br_taken),
        .MEM_mem_op   (MEM_mem_op),
        .dmem_ack     (dmem_ack),
        .dmem_req     (dmem_req),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idexe_en     (idexe_en),
        .idexe_flush  (idexe_flush),
        .exemem_en    (exemem_en),
        .memwb_flush  (memwb_flush),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rs = 1'b0; ID_uses_rt = 1'b0;
        EXE_wraddr = 5'd0; EXE_wr_en = 1'b0; EXE_is_load = 1'b0; EXE_br_taken = 1'b0;
        MEM_mem_op = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic model_clear();
        m_wait = 1'b0; m_frozen = 0; m_err = 1'b0; m_stalls = 0;
    endtask

    // Bit 8: frozen; bits 7..0: {req, pc_en, ifid_en, ifid_flush, idexe_en, idexe_flush,
    // exemem_en, memwb_flush}.
    function automatic logic [8:0] model_exp();
        bit req, hold, lu;
        if (rst) return 9'h000;
        req  = m_wait || MEM_mem_op;
        hold = req && !dmem_ack;
        lu   = EXE_is_load && EXE_wr_en && (EXE_wraddr != 5'd0) &&
               ((ID_uses_rs && (ID_rs == EXE_wraddr)) || (ID_uses_rt && (ID_rt == EXE_wraddr)));
        if (hold)              return {1'b1, req, 7'b0000001};
        else if (EXE_br_taken) return {1'b0, req, 7'b1111110};
        else if (lu)           return {1'b0, req, 7'b0001110};
        else                   return {1'b0, req, 7'b1101010};
    endfunction

    task automatic model_edge(input logic [8:0] e);
        if (rst) begin
            model_clear();
            return;
        end
        if (!e[6] && m_stalls < CntMax) m_stalls++;
        if (e[8]) begin
            m_wait = 1'b1;
            m_frozen++;
            if (m_frozen >= int'(MaxWait)) m_err = 1'b1;
        end else if (m_wait) begin
            m_wait   = 1'b0;
            m_frozen = 0;
        end
    endtask

    // Called just after a falling edge with inputs already applied; returns at the next one.
    task automatic cycle(input bit chk);
        logic [8:0] e;
        #1;
        e = model_exp();
        if (chk) begin
            check("ctrl", 32'({dmem_req, pc_en, ifid_en, ifid_flush, idexe_en, idexe_flush,
                               exemem_en, memwb_flush}), 32'(e[7:0]));
            check("flush_vs_en", 32'((ifid_flush & ~ifid_en) | (idexe_flush & ~idexe_en)), 32'd0);
        end
        @(posedge clk);
        model_edge(e);
        #1;
        if (chk) begin
            check("mem_err", 32'(mem_err), 32'(m_err));
            check("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
        end
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        MEM_mem_op = 1'b1;
        model_clear();
        @(negedge clk);
        cycle(1);
        check("rst_outputs", 32'({dmem_req, pc_en, ifid_en, idexe_en, exemem_en}), 32'd0);
        rst = 1'b0;
        MEM_mem_op = 1'b0;
        cycle(1);

        // Load-use on rs: one bubble, then normal once the load moves on.
        base = m_stalls;
        EXE_is_load = 1'b1; EXE_wr_en = 1'b1; EXE_wraddr = 5'd5; ID_rs = 5'd5; ID_uses_rs = 1'b1;
        #1;
        check("lu_ctrl", 32'({pc_en, ifid_en, idexe_flush, exemem_en}), 32'b0011);
        cycle(1);
        check("lu_stall_cnt", 32'(stall_cnt), 32'(base + 1));
        EXE_is_load = 1'b0; EXE_wraddr = 5'd7;
        cycle(1);
        EXE_is_load = 1'b1; EXE_wraddr = 5'd0; ID_rs = 5'd0;
        cycle(1);
        check("lu_r0_no_stall", 32'(stall_cnt), 32'(base + 1));

        // Branch wins over a simultaneous load-use (via rt).
        EXE_wraddr = 5'd9; ID_uses_rs = 1'b0; ID_rt = 5'd9; ID_uses_rt = 1'b1; EXE_br_taken = 1'b1;
        #1;
        check("br_ctrl", 32'({pc_en, ifid_flush, idexe_flush}), 32'b111);
        cycle(1);
        idle_inputs();
        cycle(1);

        // Memory op acked three cycles late.
        base = m_stalls;
        MEM_mem_op = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mw_freeze", 32'({dmem_req, pc_en, memwb_flush}), 32'b101);
            cycle(1);
        end
        dmem_ack = 1'b1;
        #1;
        check("mw_ack_cycle", 32'({dmem_req, pc_en, exemem_en, memwb_flush}), 32'b1110);
        cycle(1);
        check("mw_stall_cnt", 32'(stall_cnt), 32'(base + 3));
        MEM_mem_op = 1'b0; dmem_ack = 1'b0;
        cycle(1);

        // Zero-wait ack: no stall and the FSM stays in RUN.
        base = m_stalls;
        MEM_mem_op = 1'b1; dmem_ack = 1'b1;
        cycle(1);
        MEM_mem_op = 1'b0; dmem_ack = 1'b0;
        #1;
        check("zw_no_req", 32'(dmem_req), 32'd0);
        check("zw_stall_cnt", 32'(stall_cnt), 32'(base));
        cycle(1);

        // Timeout: error after MAX_WAIT frozen cycles, sticky past the late ack.
        MEM_mem_op = 1'b1;
        for (int i = 0; i < int'(MaxWait) - 1; i++) cycle(1);
        check("to_before", 32'(mem_err), 32'd0);
        cycle(1);
        check("to_set", 32'(mem_err), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1);
        dmem_ack = 1'b1;
        cycle(1);
        MEM_mem_op = 1'b0; dmem_ack = 1'b0;
        cycle(1);
        check("to_sticky", 32'(mem_err), 32'd1);

        // Reset in the middle of a wait.
        MEM_mem_op = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1);
        rst = 1'b1;
        model_clear();
        #1;
        check("rst_mid_req", 32'({dmem_req, pc_en, ifid_en, idexe_en, exemem_en}), 32'd0);
        check("rst_mid_cnt", 32'({mem_err, stall_cnt}), 32'd0);
        cycle(1);
        rst = 1'b0;
        MEM_mem_op = 1'b0;
        #1;
        check("post_rst_req", 32'(dmem_req), 32'd0);
        cycle(1);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            ID_rs        = 5'($urandom_range(0, 3));
            ID_rt        = 5'($urandom_range(0, 3));
            ID_uses_rs   = 1'($urandom_range(0, 1));
            ID_uses_rt   = 1'($urandom_range(0, 1));
            EXE_wraddr   = 5'($urandom_range(0, 3));
            EXE_wr_en    = 1'($urandom_range(0, 1));
            EXE_is_load  = 1'($urandom_range(0, 1));
            EXE_br_taken = ($urandom_range(0, 7) == 0);
            MEM_mem_op   = ($urandom_range(0, 3) == 0);
            dmem_ack     = 1'($urandom_range(0, 1));
            cycle(1);
        end

        // Long freeze drives the stall counter into saturation.
        idle_inputs();
        MEM_mem_op = 1'b1;
        for (int i = 0; i < CntMax + 5; i++) cycle(0);
        check("sat_value", 32'(stall_cnt), 32'h0000_ffff);
        cycle(1);
        cycle(1);
        dmem_ack = 1'b1;
        cycle(1);
        idle_inputs();
        cycle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
